// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: program-memory and decode handshake bundle for fetch_ctrl.
interface fetch_ctrl_if;
  logic [31:0] pm_addr;
  logic [31:0] pm_data;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fault;
  modport master (
    output pm_addr, instr, instr_pc, instr_valid, fault,
    input  pm_data, branch_valid, branch_target, halt, instr_ready
  );
  modport slave (
    input  pm_addr, instr, instr_pc, instr_valid, fault,
    output pm_data, branch_valid, branch_target, halt, instr_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, fetches from combinational program memory into a one-entry valid/ready stage.
// Define FETCH_BOUND_CHECK_EN to trap out-of-range fetches/branches in a sticky FAULT state.
module fetch_ctrl #(
  parameter int DEPTH    = 31,
  parameter int RESET_PC = 0
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.master bus
);
`ifdef FETCH_BOUND_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, HALTED, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
`endif
  localparam logic [31:0] L_DEPTH = 32'(DEPTH);
  localparam logic [31:0] L_RPC   = 32'(RESET_PC);
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_valid;
  logic        w_free;
  logic        w_bad_tgt;
  logic [31:0] w_pc_inc;
  assign w_free    = !r_valid || bus.instr_ready;
  assign w_bad_tgt = bus.branch_target >= L_DEPTH;
`ifdef FETCH_BOUND_CHECK_EN
  logic r_fault;
  assign w_pc_inc  = r_pc + 32'd1;
  assign bus.fault = r_fault;
`else
  assign w_pc_inc  = (r_pc >= L_DEPTH - 32'd1) ? '0 : r_pc + 32'd1;
  assign bus.fault = 1'b0;
`endif
  assign bus.pm_addr     = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= L_RPC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= bus.halt ? HALTED : FETCH;
          if (bus.branch_valid) begin
`ifdef FETCH_BOUND_CHECK_EN
            if (w_bad_tgt) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else r_pc <= bus.branch_target;
`else
            r_pc <= w_bad_tgt ? '0 : bus.branch_target;
`endif
          end
        end
        FETCH, HALTED: begin
          // a redirect discards the held instruction even if decode is taking it
          if (bus.branch_valid) begin
            r_valid <= 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
            if (w_bad_tgt) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else r_pc <= bus.branch_target;
`else
            r_pc <= w_bad_tgt ? '0 : bus.branch_target;
`endif
          end else if (bus.halt || r_state == HALTED) begin
            if (bus.instr_ready) r_valid <= 1'b0;
            r_state <= bus.halt ? HALTED : FETCH;
          end else if (w_free) begin
`ifdef FETCH_BOUND_CHECK_EN
            if (r_pc >= L_DEPTH) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
              r_valid <= 1'b0;
            end else begin
              r_instr    <= bus.pm_data;
              r_instr_pc <= r_pc;
              r_valid    <= 1'b1;
              r_pc       <= w_pc_inc;
            end
`else
            r_instr    <= bus.pm_data;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= w_pc_inc;
`endif
          end
        end
`ifdef FETCH_BOUND_CHECK_EN
        FAULT: r_valid <= 1'b0;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl with program memory mem[i] = 0x100 + i.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  fetch_ctrl_if bus();
  fetch_ctrl #(.DEPTH(31), .RESET_PC(0)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  assign bus.pm_data = 32'h100 + bus.pm_addr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic stage(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(v));
    chk({tag, "_pc"}, bus.instr_pc, pc);
    chk({tag, "_instr"}, bus.instr, ins);
  endtask
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    stage(tag, 1'b0, 32'd0, 32'd0);
    chk({tag, "_addr"}, bus.pm_addr, 32'd0);
    chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
    tick(1);
    reset = 1'b0;
  endtask
  initial begin
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    bus.halt          = 1'b0;
    bus.instr_ready   = 1'b1;
    tick(2);
    stage("rst", 1'b0, 32'd0, 32'd0);
    chk("rst_addr", bus.pm_addr, 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("idle_valid", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      stage("seq", 1'b1, 32'(i), 32'h100 + 32'(i));
    end
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      stage("stall", 1'b1, 32'd2, 32'h102);
      chk("stall_addr", bus.pm_addr, 32'd3);
    end
    bus.instr_ready = 1'b1;
    tick(1);
    stage("release", 1'b1, 32'd3, 32'h103);
    tick(1);
    stage("pre_br", 1'b1, 32'd4, 32'h104);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'd20;
    tick(1);
    chk("br_valid", 32'(bus.instr_valid), 32'd0);
    chk("br_addr", bus.pm_addr, 32'd20);
    bus.branch_valid = 1'b0;
    tick(1);
    stage("br_cap", 1'b1, 32'd20, 32'h114);
    chk("br_next", bus.pm_addr, 32'd21);
    bus.halt = 1'b1;
    tick(1);
    chk("halt_valid", 32'(bus.instr_valid), 32'd0);
    chk("halt_addr", bus.pm_addr, 32'd21);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'd7;
    tick(1);
    chk("hbr_valid", 32'(bus.instr_valid), 32'd0);
    chk("hbr_addr", bus.pm_addr, 32'd7);
    bus.branch_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("halted_valid", 32'(bus.instr_valid), 32'd0);
      chk("halted_addr", bus.pm_addr, 32'd7);
    end
    bus.halt = 1'b0;
    tick(1);
    chk("unhalt_valid", 32'(bus.instr_valid), 32'd0);
    tick(1);
    stage("resume", 1'b1, 32'd7, 32'h107);
    for (int i = 8; i <= 30; i++) begin
      tick(1);
      chk("run_pc", bus.instr_pc, 32'(i));
    end
`ifdef FETCH_BOUND_CHECK_EN
    chk("edge_addr", bus.pm_addr, 32'd31);
    tick(1);
    chk("flt_fault", 32'(bus.fault), 32'd1);
    chk("flt_valid", 32'(bus.instr_valid), 32'd0);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'd3;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("flt_stick", 32'(bus.fault), 32'd1);
      chk("flt_hold_valid", 32'(bus.instr_valid), 32'd0);
      chk("flt_pc", bus.pm_addr, 32'd31);
    end
    bus.branch_valid = 1'b0;
    async_reset("flt_rst");
    tick(2);
    stage("restart", 1'b1, 32'd0, 32'h100);
    tick(1);
    stage("restart2", 1'b1, 32'd1, 32'h101);
`else
    chk("wrap_addr", bus.pm_addr, 32'd0);
    tick(1);
    stage("wrap", 1'b1, 32'd0, 32'h100);
    tick(1);
    stage("wrap2", 1'b1, 32'd1, 32'h101);
`endif
    async_reset("arst");
    tick(2);
    stage("post_rst", 1'b1, 32'd0, 32'h100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
